lcd_ctrl_gen: RTL and testbench
===============================

# lcd_ctrl_gen

Parametrised next-generation LCD image controller. Loads a `IMG_W`×`IMG_H` image of `DW`-bit pixels from IROM into an internal buffer, then executes a command stream on a 2×2 window around a movable operation point. The stream includes shifts, max/min/average fill and new mirror/rotate modes. On the write command it dumps the buffer to IRAM and pulses `done`. It sits between the command source and the IROM/IRAM pair, replacing the fixed 8×8, 8-bit controller.

## Interface
- `IMG_W`, 8, image width in pixels; even, ≥2
- `IMG_H`, 8, image height in pixels; even, ≥2
- `DW`, 8, pixel width in bits
- `AW`, `$clog2(IMG_W*IMG_H)`, address width (derived; not overridden)

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `reset`  in  1  synchronous, active-low (0 = reset), sampled on posedge `clk`
- `cmd`  in  4  command code
- `cmd_valid`  in  1  command strobe; accepted only when `busy`=0
- `IROM_rd`  out  1  IROM read enable
- `IROM_A`  out  AW  IROM address
- `IROM_Q`  in  DW  IROM data; valid at the posedge ending the cycle its address was driven
- `IRAM_valid`  out  1  IRAM write enable
- `IRAM_D`  out  DW  IRAM write data
- `IRAM_A`  out  AW  IRAM write address
- `busy`  out  1  controller cannot accept a command
- `done`  out  1  one-cycle pulse after the IRAM dump completes

## Operation
- Pixel (x,y) is stored at address y·IMG_W+x. The buffer has IMG_W·IMG_H entries and is not reset.
- Operation point (x,y) resets to (IMG_W/2, IMG_H/2). The window is P0=(x-1,y-1), P1=(x,y-1), P2=(x-1,y), P3=(x,y).
- FSM states:
  - LOAD: entered when `reset` goes high.
  - IDLE: `busy`=0, waits for a command.
  - EXEC: one cycle.
  - WRITE: IMG_W·IMG_H cycles.
  - DONE: one cycle, then IDLE.
- Command codes:
  - 0 Write: go to WRITE.
  - 1 Up: y-1, clamped at 1.
  - 2 Down: y+1, clamped at IMG_H-1.
  - 3 Left: x-1, clamped at 1.
  - 4 Right: x+1, clamped at IMG_W-1.
  - 5 Max: all four window pixels ← max(P0..P3).
  - 6 Min: all four ← min.
  - 7 Average: all four ← floor((P0+P1+P2+P3)/4). The sum is computed in DW+2 bits, so there is no overflow.
  - 8 Mirror X: swap P0↔P1 and P2↔P3.
  - 9 Mirror Y: swap P0↔P2 and P1↔P3.
  - 10 Rotate CW: P0←P2, P1←P0, P3←P1, P2←P3.
  - 11 Rotate CCW: P0←P1, P1←P3, P3←P2, P2←P0.
  - 12–15 Reserved: NOP, still one EXEC cycle.
- A shift that hits a clamp leaves the point unchanged and still costs one EXEC cycle.
- `cmd_valid` while `busy`=1 is ignored; the command is not queued.
- Multiple Write commands are allowed. Each one re-dumps the current buffer and pulses `done`.

## Timing
- Reset values (any cycle with `reset`=0):
  - Outputs: `busy`=1, `done`=0, `IROM_rd`=0, `IROM_A`=0, `IRAM_valid`=0, `IRAM_D`=0, `IRAM_A`=0.
  - State: FSM returns to LOAD and the operation point resets. Asserting reset mid-LOAD or mid-WRITE aborts that operation immediately, with no further IRAM writes.
- LOAD, for k = 0..N-1 (N = IMG_W·IMG_H):
  - Cycle k after reset release: `IROM_rd`=1, `IROM_A`=k.
  - The posedge ending cycle k writes `IROM_Q` into buf[k].
  - After N cycles: IDLE, `busy`=0, `IROM_rd`=0.
- Command accept: posedge with `busy`=0 and `cmd_valid`=1. `busy` is 1 in the following cycle.
  - Non-write commands: exactly 1 busy cycle. The result is visible to the next accepted command.
- WRITE, cycle k (k = 0..N-1): `IRAM_valid`=1, `IRAM_A`=k, `IRAM_D`=buf[k]. The write uses the buffer after all prior commands.
- DONE: the next cycle has `done`=1, `busy`=1, `IRAM_valid`=0. `busy`=0 in the cycle after.
  - Write command total: N+1 busy cycles.
- Outputs are registered; no combinational path from `cmd`/`cmd_valid` to any output.

## Test plan
- **Default load and dump:** params 8/8/8; reset; load ramp image buf[k]=k; then cmd 0.
  - `busy` is high for 64 cycles after reset.
  - IRAM[k]=k for all k; `done` is a single pulse 65 cycles after accept.
- **Window ops:** same image; cmds 7, then 0.
  - Window at (4,4) is addresses 27, 28, 35, 36; average of 27,28,35,36 = 31.
  - All four addresses read 31; all others are unchanged.
- **Clamping:** cmd 3 issued 5 times, then cmd 1 issued 5 times, then 5, then 0.
  - Point clamps at (1,1); addresses 0, 1, 8, 9 read max=9.
- **Mirror/rotate:** window values 10, 20, 30, 40.
  - cmd 10 → P0..P3 = 30, 10, 40, 20.
  - Then cmd 11 restores 10, 20, 30, 40.
  - cmd 8 gives 20, 10, 40, 30; cmd 9 gives 30, 40, 10, 20.
- **Generalised params and handshake:** IMG_W=6, IMG_H=4, DW=10.
  - Load pixels 1023−k; cmd 6, then 0.
  - Window at (3,2) is addresses 8, 9, 14, 15 = min 1008; 24 IRAM writes.
  - `cmd_valid` held high while `busy` → no extra commands executed.
- **Reset mid-WRITE:** assert `reset`=0 at write cycle 10.
  - Next cycle `IRAM_valid`=0 and `busy`=1; no `done` pulse.
  - After release, LOAD restarts from address 0.

Source files
------------

// File: rtl/lcd_ctrl_gen_if.sv
// Command, IROM and IRAM signal bundle for lcd_ctrl_gen.
// master = the controller, slave = command source plus memories.
interface lcd_ctrl_gen_if #(
    parameter int DW = 8,
    parameter int AW = 6
);
    logic [3:0]    cmd;
    logic          cmd_valid;
    logic          IROM_rd;
    logic [AW-1:0] IROM_A;
    logic [DW-1:0] IROM_Q;
    logic          IRAM_valid;
    logic [DW-1:0] IRAM_D;
    logic [AW-1:0] IRAM_A;
    logic          busy;
    logic          done;

    modport master (
        input  cmd, cmd_valid, IROM_Q,
        output IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done
    );

    modport slave (
        output cmd, cmd_valid, IROM_Q,
        input  IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done
    );
endinterface

// File: rtl/lcd_ctrl_gen.sv
// Parametrised LCD image controller: loads an image from IROM, applies 2x2 window
// commands around a movable point, and dumps the buffer to IRAM on request.
module lcd_ctrl_gen #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int DW    = 8
) (
    input  logic           clk,
    input  logic           reset,
    lcd_ctrl_gen_if.master bus
);
    localparam int N  = IMG_W * IMG_H;
    localparam int AW = $clog2(N);
    localparam int XW = $clog2(IMG_W) + 1;
    localparam int YW = $clog2(IMG_H) + 1;
    localparam int SW = DW + 2;
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic [2:0] {S_RST, S_LOAD, S_IDLE, S_EXEC, S_WRITE, S_DONE} state_t;

    state_t        r_state, w_nxt_state;
    logic [AW-1:0] r_cnt, w_nxt_cnt;
    logic [3:0]    r_cmd;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [DW-1:0] r_buf [N];

    logic          r_irom_rd, w_irom_rd;
    logic [AW-1:0] r_irom_a, w_irom_a;
    logic          r_iram_valid, w_iram_valid;
    logic [DW-1:0] r_iram_d, w_iram_d;
    logic [AW-1:0] r_iram_a, w_iram_a;
    logic          r_busy, w_busy;
    logic          r_done, w_done;

    logic [AW-1:0] w_a0, w_a1, w_a2, w_a3;
    logic [DW-1:0] w_p0, w_p1, w_p2, w_p3;
    logic [DW-1:0] w_max01, w_max23, w_max, w_min01, w_min23, w_min, w_avg;
    logic [SW-1:0] w_sum;

    assign w_a3 = AW'(int'(r_y) * IMG_W + int'(r_x));
    assign w_a2 = w_a3 - AW'(1);
    assign w_a1 = w_a3 - AW'(IMG_W);
    assign w_a0 = w_a1 - AW'(1);

    assign w_p0 = r_buf[w_a0];
    assign w_p1 = r_buf[w_a1];
    assign w_p2 = r_buf[w_a2];
    assign w_p3 = r_buf[w_a3];

    assign w_max01 = (w_p0 > w_p1) ? w_p0 : w_p1;
    assign w_max23 = (w_p2 > w_p3) ? w_p2 : w_p3;
    assign w_max   = (w_max01 > w_max23) ? w_max01 : w_max23;
    assign w_min01 = (w_p0 < w_p1) ? w_p0 : w_p1;
    assign w_min23 = (w_p2 < w_p3) ? w_p2 : w_p3;
    assign w_min   = (w_min01 < w_min23) ? w_min01 : w_min23;
    assign w_sum   = SW'(w_p0) + SW'(w_p1) + SW'(w_p2) + SW'(w_p3);
    assign w_avg   = DW'(w_sum >> 2);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_RST;
            r_cnt        <= '0;
            r_irom_rd    <= 1'b0;
            r_irom_a     <= '0;
            r_iram_valid <= 1'b0;
            r_iram_d     <= '0;
            r_iram_a     <= '0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_cnt        <= w_nxt_cnt;
            r_irom_rd    <= w_irom_rd;
            r_irom_a     <= w_irom_a;
            r_iram_valid <= w_iram_valid;
            r_iram_d     <= w_iram_d;
            r_iram_a     <= w_iram_a;
            r_busy       <= w_busy;
            r_done       <= w_done;
        end
    end

    // S_RST holds outputs quiet while reset is low; LOAD cycle 0 starts at release.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        case (r_state)
            S_RST: begin
                w_nxt_state = S_LOAD;
                w_nxt_cnt   = '0;
            end
            S_LOAD: begin
                if (r_cnt == LAST) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt = r_cnt + AW'(1);
                end
            end
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    w_nxt_state = (bus.cmd == 4'd0) ? S_WRITE : S_EXEC;
                    w_nxt_cnt   = '0;
                end
            end
            S_EXEC:  w_nxt_state = S_IDLE;
            S_WRITE: begin
                if (r_cnt == LAST) begin
                    w_nxt_state = S_DONE;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt = r_cnt + AW'(1);
                end
            end
            S_DONE:  w_nxt_state = S_IDLE;
            default: w_nxt_state = S_RST;
        endcase
    end

    // Outputs are decoded from the upcoming state and registered at the same edge.
    always_comb begin
        w_irom_rd    = (w_nxt_state == S_LOAD);
        w_irom_a     = w_irom_rd ? w_nxt_cnt : '0;
        w_iram_valid = (w_nxt_state == S_WRITE);
        w_iram_a     = w_iram_valid ? w_nxt_cnt : '0;
        w_iram_d     = w_iram_valid ? r_buf[w_nxt_cnt] : '0;
        w_busy       = (w_nxt_state != S_IDLE);
        w_done       = (w_nxt_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cmd <= '0;
            r_x   <= XW'(IMG_W / 2);
            r_y   <= YW'(IMG_H / 2);
        end else if (r_state == S_IDLE && bus.cmd_valid) begin
            r_cmd <= bus.cmd;
        end else if (r_state == S_EXEC) begin
            case (r_cmd)
                4'd1:    if (r_y > YW'(1))         r_y <= r_y - YW'(1);
                4'd2:    if (r_y < YW'(IMG_H - 1)) r_y <= r_y + YW'(1);
                4'd3:    if (r_x > XW'(1))         r_x <= r_x - XW'(1);
                4'd4:    if (r_x < XW'(IMG_W - 1)) r_x <= r_x + XW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset && r_state == S_LOAD) begin
            r_buf[r_cnt] <= bus.IROM_Q;
        end else if (reset && r_state == S_EXEC) begin
            case (r_cmd)
                4'd5: begin
                    r_buf[w_a0] <= w_max; r_buf[w_a1] <= w_max;
                    r_buf[w_a2] <= w_max; r_buf[w_a3] <= w_max;
                end
                4'd6: begin
                    r_buf[w_a0] <= w_min; r_buf[w_a1] <= w_min;
                    r_buf[w_a2] <= w_min; r_buf[w_a3] <= w_min;
                end
                4'd7: begin
                    r_buf[w_a0] <= w_avg; r_buf[w_a1] <= w_avg;
                    r_buf[w_a2] <= w_avg; r_buf[w_a3] <= w_avg;
                end
                4'd8: begin
                    r_buf[w_a0] <= w_p1; r_buf[w_a1] <= w_p0;
                    r_buf[w_a2] <= w_p3; r_buf[w_a3] <= w_p2;
                end
                4'd9: begin
                    r_buf[w_a0] <= w_p2; r_buf[w_a2] <= w_p0;
                    r_buf[w_a1] <= w_p3; r_buf[w_a3] <= w_p1;
                end
                4'd10: begin
                    r_buf[w_a0] <= w_p2; r_buf[w_a1] <= w_p0;
                    r_buf[w_a3] <= w_p1; r_buf[w_a2] <= w_p3;
                end
                4'd11: begin
                    r_buf[w_a0] <= w_p1; r_buf[w_a1] <= w_p3;
                    r_buf[w_a3] <= w_p2; r_buf[w_a2] <= w_p0;
                end
                default: ;
            endcase
        end
    end

    assign bus.IROM_rd    = r_irom_rd;
    assign bus.IROM_A     = r_irom_a;
    assign bus.IRAM_valid = r_iram_valid;
    assign bus.IRAM_D     = r_iram_d;
    assign bus.IRAM_A     = r_iram_a;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_lcd_ctrl_gen.sv
// Directed bench for lcd_ctrl_gen: default 8x8x8 instance and a 6x4x10 instance.
module tb_lcd_ctrl_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1 = 1'b0;
    logic rst2 = 1'b0;

    lcd_ctrl_gen_if #(.DW(8),  .AW(6)) b1 ();
    lcd_ctrl_gen_if #(.DW(10), .AW(5)) b2 ();

    lcd_ctrl_gen u_dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (b1.master)
    );

    lcd_ctrl_gen #(.IMG_W(6), .IMG_H(4), .DW(10)) u_dut2 (
        .clk   (clk),
        .reset (rst2),
        .bus   (b2.master)
    );

    logic [7:0] rom1 [64];
    logic [7:0] iram1 [64];
    logic [7:0] exp1 [64];
    logic [9:0] rom2 [24];
    logic [9:0] iram2 [24];
    logic [9:0] exp2 [24];

    int wr1 = 0, wr2 = 0, done1 = 0, done2 = 0;
    int errors = 0, checks = 0;

    assign b1.IROM_Q = rom1[b1.IROM_A];
    assign b2.IROM_Q = (b2.IROM_A < 5'd24) ? rom2[b2.IROM_A] : '0;

    always @(posedge clk) begin
        if (b1.IRAM_valid === 1'b1) begin
            iram1[b1.IRAM_A] <= b1.IRAM_D;
            wr1 <= wr1 + 1;
        end
        if (b1.done === 1'b1) done1 <= done1 + 1;
        if (b2.IRAM_valid === 1'b1) begin
            if (b2.IRAM_A < 5'd24) iram2[b2.IRAM_A] <= b2.IRAM_D;
            wr2 <= wr2 + 1;
        end
        if (b2.done === 1'b1) done2 <= done2 + 1;
    end

    function automatic logic busy_of(input int sel);
        return (sel == 2) ? b2.busy : b1.busy;
    endfunction

    function automatic logic done_of(input int sel);
        return (sel == 2) ? b2.done : b1.done;
    endfunction

    function automatic logic valid_of(input int sel);
        return (sel == 2) ? b2.IRAM_valid : b1.IRAM_valid;
    endfunction

    task automatic set_valid(input int sel, input logic v);
        if (sel == 2) b2.cmd_valid = v; else b1.cmd_valid = v;
    endtask

    task automatic do_reset(input int sel);
        int guard;
        @(negedge clk);
        if (sel == 2) rst2 = 1'b0; else rst1 = 1'b0;
        repeat (2) @(negedge clk);
        if (sel == 2) rst2 = 1'b1; else rst1 = 1'b1;
        guard = 0;
        @(negedge clk);
        while (busy_of(sel) !== 1'b0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            checks++; errors++;
            $display("FAIL load_timeout: busy still %b after %0d cycles, want 0", busy_of(sel), guard);
        end
    endtask

    // Issues one command; reports busy-cycle count, the busy cycle holding done, and IRAM_valid then.
    task automatic issue(input int sel, input logic [3:0] c, input bit hold,
                         output int nbusy, output int done_at, output logic vdone);
        int guard;
        nbusy = 0; done_at = 0; vdone = 1'bx; guard = 0;
        @(negedge clk);
        while (busy_of(sel) !== 1'b0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (sel == 2) b2.cmd = c; else b1.cmd = c;
        set_valid(sel, 1'b1);
        @(negedge clk);
        if (!hold) set_valid(sel, 1'b0);
        while (busy_of(sel) === 1'b1 && nbusy < 2000) begin
            nbusy++;
            if (done_of(sel) === 1'b1 && done_at == 0) begin
                done_at = nbusy;
                vdone = valid_of(sel);
            end
            @(negedge clk);
        end
        set_valid(sel, 1'b0);
        if (guard >= 2000 || nbusy >= 2000) begin
            checks++; errors++;
            $display("FAIL issue_timeout: cmd %0d guard=%0d busy_cycles=%0d, want bounded", c, guard, nbusy);
        end
    endtask

    task automatic test_reset;
        int nb, bad;
        for (int k = 0; k < 64; k++) rom1[k] = 8'(k);
        rst1 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({b1.busy, b1.done, b1.IROM_rd, b1.IRAM_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags: busy,done,rd,valid=%b want 1000",
                     {b1.busy, b1.done, b1.IROM_rd, b1.IRAM_valid});
        end
        checks++;
        if (b1.IROM_A !== 6'd0 || b1.IRAM_A !== 6'd0 || b1.IRAM_D !== 8'd0) begin
            errors++;
            $display("FAIL reset_buses: IROM_A=%0d IRAM_A=%0d IRAM_D=%0d want 0 0 0",
                     b1.IROM_A, b1.IRAM_A, b1.IRAM_D);
        end
        rst1 = 1'b1;
        @(negedge clk);
        nb = 0; bad = 0;
        while (b1.busy === 1'b1 && nb < 200) begin
            if (b1.IROM_rd !== 1'b1 || b1.IROM_A !== 6'(nb)) bad++;
            nb++;
            @(negedge clk);
        end
        checks++;
        if (nb != 64) begin
            errors++;
            $display("FAIL load_busy_cycles: got %0d want 64", nb);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL load_addr_seq: %0d cycles with wrong rd/address, want 0", bad);
        end
        checks++;
        if (b1.IROM_rd !== 1'b0 || b1.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_load: rd=%b busy=%b want 0 0", b1.IROM_rd, b1.busy);
        end
    endtask

    task automatic test_load_dump;
        int nb, da, w0, d0, bad;
        logic vd;
        for (int k = 0; k < 64; k++) exp1[k] = 8'(k);
        w0 = wr1; d0 = done1;
        issue(1, 4'd0, 1'b0, nb, da, vd);
        checks++;
        if (nb != 65 || da != 65) begin
            errors++;
            $display("FAIL write_timing: busy=%0d done_at=%0d want 65 65", nb, da);
        end
        checks++;
        if (vd !== 1'b0) begin
            errors++;
            $display("FAIL done_valid: IRAM_valid=%b during done, want 0", vd);
        end
        checks++;
        if (wr1 - w0 != 64 || done1 - d0 != 1) begin
            errors++;
            $display("FAIL write_counts: writes=%0d done=%0d want 64 1", wr1 - w0, done1 - d0);
        end
        bad = 0;
        for (int k = 0; k < 64; k++) if (iram1[k] !== exp1[k]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ramp_dump: %0d addresses differ, addr63 got %0d want 63", bad, iram1[63]);
        end
    endtask

    task automatic test_average;
        int nb, da, bad;
        logic vd;
        int wa [4] = '{27, 28, 35, 36};
        issue(1, 4'd7, 1'b0, nb, da, vd);
        checks++;
        if (nb != 1) begin
            errors++;
            $display("FAIL avg_busy: got %0d want 1", nb);
        end
        issue(1, 4'd0, 1'b0, nb, da, vd);
        for (int i = 0; i < 4; i++) begin
            exp1[wa[i]] = 8'd31;
            checks++;
            if (iram1[wa[i]] !== 8'd31) begin
                errors++;
                $display("FAIL avg_pixel: addr %0d got %0d want 31", wa[i], iram1[wa[i]]);
            end
        end
        bad = 0;
        for (int k = 0; k < 64; k++) if (iram1[k] !== exp1[k]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL avg_others: %0d addresses differ, want 0", bad);
        end
    endtask

    task automatic test_clamp;
        int nb, da, bad, slow;
        logic vd;
        do_reset(1);
        for (int k = 0; k < 64; k++) exp1[k] = 8'(k);
        slow = 0;
        for (int i = 0; i < 5; i++) begin
            issue(1, 4'd3, 1'b0, nb, da, vd);
            if (nb != 1) slow++;
        end
        for (int i = 0; i < 5; i++) begin
            issue(1, 4'd1, 1'b0, nb, da, vd);
            if (nb != 1) slow++;
        end
        checks++;
        if (slow != 0) begin
            errors++;
            $display("FAIL shift_busy: %0d shifts not 1 cycle, want 0", slow);
        end
        issue(1, 4'd5, 1'b0, nb, da, vd);
        issue(1, 4'd0, 1'b0, nb, da, vd);
        exp1[0] = 8'd9; exp1[1] = 8'd9; exp1[8] = 8'd9; exp1[9] = 8'd9;
        checks++;
        if (iram1[0] !== 8'd9) begin
            errors++;
            $display("FAIL clamp_max: addr 0 got %0d want 9", iram1[0]);
        end
        bad = 0;
        for (int k = 0; k < 64; k++) if (iram1[k] !== exp1[k]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clamp_image: %0d addresses differ, addr9 got %0d want 9", bad, iram1[9]);
        end
    endtask

    task automatic test_mirror_rotate;
        int nb, da, bad;
        logic vd;
        int wa [4] = '{27, 28, 35, 36};
        logic [3:0] ops [6] = '{4'd10, 4'd11, 4'd8, 4'd8, 4'd9, 4'd13};
        int want [6][4] = '{'{30, 10, 40, 20}, '{10, 20, 30, 40}, '{20, 10, 40, 30},
                            '{10, 20, 30, 40}, '{30, 40, 10, 20}, '{30, 40, 10, 20}};
        for (int k = 0; k < 64; k++) rom1[k] = 8'(k);
        rom1[27] = 8'd10; rom1[28] = 8'd20; rom1[35] = 8'd30; rom1[36] = 8'd40;
        do_reset(1);
        for (int s = 0; s < 6; s++) begin
            issue(1, ops[s], 1'b0, nb, da, vd);
            if (ops[s] == 4'd13) begin
                checks++;
                if (nb != 1) begin
                    errors++;
                    $display("FAIL reserved_busy: got %0d want 1", nb);
                end
            end
            issue(1, 4'd0, 1'b0, nb, da, vd);
            for (int k = 0; k < 64; k++) exp1[k] = 8'(k);
            for (int i = 0; i < 4; i++) exp1[wa[i]] = 8'(want[s][i]);
            bad = 0;
            for (int k = 0; k < 64; k++) if (iram1[k] !== exp1[k]) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL window_cmd%0d: P0..P3 got %0d %0d %0d %0d want %0d %0d %0d %0d",
                         ops[s], iram1[27], iram1[28], iram1[35], iram1[36],
                         want[s][0], want[s][1], want[s][2], want[s][3]);
            end
        end
    endtask

    task automatic test_generic;
        int nb, da, bad, w0, d0;
        logic vd;
        for (int k = 0; k < 24; k++) begin
            rom2[k] = 10'(1023 - k);
            exp2[k] = 10'(1023 - k);
        end
        do_reset(2);
        issue(2, 4'd6, 1'b0, nb, da, vd);
        w0 = wr2; d0 = done2;
        issue(2, 4'd0, 1'b1, nb, da, vd);
        checks++;
        if (nb != 25 || da != 25) begin
            errors++;
            $display("FAIL g_write_timing: busy=%0d done_at=%0d want 25 25", nb, da);
        end
        checks++;
        if (wr2 - w0 != 24 || done2 - d0 != 1) begin
            errors++;
            $display("FAIL g_held_write: writes=%0d done=%0d want 24 1", wr2 - w0, done2 - d0);
        end
        exp2[8] = 10'd1008; exp2[9] = 10'd1008; exp2[14] = 10'd1008; exp2[15] = 10'd1008;
        bad = 0;
        for (int k = 0; k < 24; k++) if (iram2[k] !== exp2[k]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL g_min_image: %0d differ, addr15 got %0d want 1008", bad, iram2[15]);
        end
        issue(2, 4'd4, 1'b1, nb, da, vd);
        checks++;
        if (nb != 1) begin
            errors++;
            $display("FAIL g_held_shift_busy: got %0d want 1", nb);
        end
        issue(2, 4'd6, 1'b0, nb, da, vd);
        issue(2, 4'd0, 1'b0, nb, da, vd);
        exp2[9] = 10'd1007; exp2[10] = 10'd1007; exp2[15] = 10'd1007; exp2[16] = 10'd1007;
        bad = 0;
        for (int k = 0; k < 24; k++) if (iram2[k] !== exp2[k]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL g_single_shift: %0d differ, addr16 got %0d want 1007", bad, iram2[16]);
        end
    endtask

    task automatic test_reset_mid_write;
        int w0, d0, guard;
        w0 = wr1; d0 = done1;
        @(negedge clk);
        b1.cmd = 4'd0;
        b1.cmd_valid = 1'b1;
        @(negedge clk);
        b1.cmd_valid = 1'b0;
        guard = 0;
        while (!(b1.IRAM_valid === 1'b1 && b1.IRAM_A === 6'd10) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 100) begin
            errors++;
            $display("FAIL reach_write10: not seen in %0d cycles, want seen", guard);
        end
        rst1 = 1'b0;
        @(negedge clk);
        checks++;
        if (b1.IRAM_valid !== 1'b0 || b1.busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_write: valid=%b busy=%b want 0 1", b1.IRAM_valid, b1.busy);
        end
        @(negedge clk);
        rst1 = 1'b1;
        @(negedge clk);
        checks++;
        if (b1.IROM_rd !== 1'b1 || b1.IROM_A !== 6'd0) begin
            errors++;
            $display("FAIL reload_start: rd=%b A=%0d want 1 0", b1.IROM_rd, b1.IROM_A);
        end
        guard = 0;
        while (b1.busy !== 1'b0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wr1 - w0 != 11 || done1 - d0 != 0) begin
            errors++;
            $display("FAIL abort_counts: writes=%0d done=%0d want 11 0", wr1 - w0, done1 - d0);
        end
    endtask

    initial begin
        b1.cmd = 4'd0; b1.cmd_valid = 1'b0;
        b2.cmd = 4'd0; b2.cmd_valid = 1'b0;
        for (int k = 0; k < 24; k++) rom2[k] = '0;
        test_reset;
        test_load_dump;
        test_average;
        test_clamp;
        test_mirror_rotate;
        test_generic;
        test_reset_mid_write;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
